alu_issue: RTL and testbench
============================

# alu_issue

Request-side sequencer for the combinational `alu`. It accepts operation requests over a valid/ready handshake and holds the operands stable on the ALU inputs for one full cycle. It then captures the ALU result and flags, with a sequence tag, into a response FIFO drained by a second valid/ready handshake. It sits between the decode/issue logic and the writeback path, and it is also the synthesizable driver used in place of hand-written ALU stimulus.

## Interface
- `DEPTH`, default 4: response FIFO entries; power of two, minimum 2.
- `TAGW`, default 8: sequence tag width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `req_op` in 6: ALU opcode, passed through unmodified.
- `alu_a` out 32: to the ALU A input.
- `alu_b` out 32: to the ALU B input.
- `alu_op` out 6: to the ALU opcode input.
- `alu_x` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `alu_sign` in 1: ALU sign flag.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer pops the head when `rsp_valid && rsp_ready` at a rising edge.
- `rsp_x` out 32: head result.
- `rsp_zero` out 1: head zero flag.
- `rsp_sign` out 1: head sign flag.
- `rsp_tag` out TAGW: head sequence tag.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Issue register.** Holds `alu_a`, `alu_b`, `alu_op`, a tag, and an `iss_v` bit.
  - On request accept, the register loads `req_a`, `req_b`, `req_op` and the current tag counter, and sets `iss_v`.
  - Otherwise `iss_v` clears and the operands hold their last values, so the ALU inputs never toggle while idle.
- **Capture.** On every edge where `iss_v` = 1, the block pushes {`alu_x`, `alu_zero`, `alu_sign`, issue tag} into the FIFO tail. It never samples ALU outputs when `iss_v` = 0.
- **Tag counter.** TAGW bits. Increments by 1 on each accepted request and wraps from 2^TAGW-1 to 0.
- **Admission.** `req_ready` = (`count` + `iss_v`) < DEPTH.
  - It is computed from registered state only; there is no combinational path from `rsp_ready` or `req_valid` to `req_ready`.
  - A pop in the same cycle does not raise `req_ready` until the following cycle.
- **FIFO.** Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap naturally.
  - `count` increments on a push without a pop, decrements on a pop without a push, and is unchanged on a simultaneous push and pop.
  - The head outputs are driven directly from the read-pointer entry; they are undefined-free because entries reset to 0.
  - When `count` = 0, `rsp_valid` = 0.
- **Ordering.** Responses emerge in strict request order; tags are consecutive modulo 2^TAGW.
- **Overflow/underflow.** Structurally impossible: the admission rule guarantees a free slot for the in-flight entry. An assertion in the bench checks this.

## Timing
- **Reset.** All state clears asynchronously on `rst_n` low, and again on the following edges while low.
  - Outputs during and after reset: `req_ready` = 1, `alu_a` = 0, `alu_b` = 0, `alu_op` = 0, `rsp_valid` = 0, `rsp_x` = 0, `rsp_zero` = 0, `rsp_sign` = 0, `rsp_tag` = 0, `count` = 0.
  - Internal state after reset: tag counter = 0, `iss_v` = 0.
- **Latency.** For a request accepted at edge N:
  - ALU inputs change just after edge N.
  - The result is captured at edge N+1.
  - `rsp_valid` is high after edge N+1 if the FIFO was empty.
- **Throughput.** One request per cycle sustained while the consumer pops every cycle.
- **Reset mid-operation.** The in-flight issue and all FIFO contents are discarded, and the tag restarts at 0.
- **Stall behaviour.**
  - `rsp_valid` held with `rsp_ready` = 0 keeps all `rsp_*` head outputs stable.
  - `req_*` inputs are ignored whenever `req_ready` = 0.

## Test plan
- **Single request.** After reset, issue A = 1234, B = 5678, op = 0 for one cycle.
  - `alu_a`/`alu_b` = 1234/5678 after edge N.
  - `rsp_valid` rises after N+1 with `rsp_x`/`rsp_zero`/`rsp_sign` equal to the ALU outputs for those operands.
  - `rsp_tag` = 0 and `count` = 1.
- **Fill with consumer stalled.** Hold `rsp_ready` = 0 and offer requests every cycle.
  - Exactly 4 are accepted (tags 0-3).
  - `req_ready` drops after the 4th accept; `count` = 4.
  - A pop raises `req_ready` one cycle later.
- **Streaming.** Run 300 back-to-back requests with `rsp_ready` = 1 and sweep op 0-63 with A = 32'h82345671, B = 32'h83455555.
  - One response per cycle, in order.
  - Tag wraps 255 -> 0 at request 256.
  - Every result matches a reference ALU model.
- **Simultaneous push/pop at count = 2.** `count` stays 2 and the head advances to the next tag.
- **Reset mid-flight.** With 3 entries queued and one in issue, pulse `rst_n` low asynchronously between edges.
  - Immediately `rsp_valid` = 0, `count` = 0, `req_ready` = 1.
  - The next accepted request gets tag 0.
- **Idle hold.** With no requests for 20 cycles after traffic, `alu_a`/`alu_b`/`alu_op` remain at the last issued values and no FIFO push occurs.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: request-side sequencer for the combinational alu.
//
// Accepts operation requests over a valid/ready handshake, holds the
// operands on the ALU inputs for one full cycle, then captures the ALU
// result, its flags and a sequence tag into a response FIFO. The FIFO is
// drained by a second valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens at a rising clk edge
// where valid && ready are both 1. A valid source holds its payload until
// that edge. Here req_ready depends on registered state only.
//
// Parameters:
//   DEPTH  response FIFO entries (power of two, >= 2)
//   TAGW   sequence tag width
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_op            request operands and opcode
//   alu_a, alu_b, alu_op            registered ALU inputs
//   alu_x, alu_zero, alu_sign       ALU result and flags
//   rsp_valid/rsp_ready             response handshake
//   rsp_x, rsp_zero, rsp_sign       FIFO head result and flags
//   rsp_tag                         FIFO head sequence tag
//   count                           FIFO occupancy
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_a,
    input  logic [31:0]                req_b,
    input  logic [5:0]                 req_op,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    output logic [5:0]                 alu_op,
    input  logic [31:0]                alu_x,
    input  logic                       alu_zero,
    input  logic                       alu_sign,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_x,
    output logic                       rsp_zero,
    output logic                       rsp_sign,
    output logic [TAGW-1:0]            rsp_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic            iss_v;
    logic [TAGW-1:0] iss_tag;
    logic [TAGW-1:0] tag_cnt;

    logic [31:0]     fifo_x    [DEPTH];
    logic            fifo_zero [DEPTH];
    logic            fifo_sign [DEPTH];
    logic [TAGW-1:0] fifo_tag  [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic accept;
    logic push;
    logic pop;

    // The in-flight issue entry is counted as already occupying a slot, so
    // its capture one cycle later always finds room.
    assign req_ready = (count + CW'(iss_v)) < CW'(DEPTH);
    assign accept    = req_valid && req_ready;
    assign push      = iss_v;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_x    = fifo_x[rd_ptr];
    assign rsp_zero = fifo_zero[rd_ptr];
    assign rsp_sign = fifo_sign[rd_ptr];
    assign rsp_tag  = fifo_tag[rd_ptr];

    // Issue register: operands only load on accept so the ALU inputs stay
    // quiet while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_v   <= 1'b0;
            iss_tag <= '0;
            tag_cnt <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
        end else begin
            iss_v <= accept;
            if (accept) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_op  <= req_op;
                iss_tag <= tag_cnt;
                tag_cnt <= tag_cnt + TAGW'(1);
            end
        end
    end

    // Response FIFO; entries reset to zero so the head is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_x[i]    <= '0;
                fifo_zero[i] <= 1'b0;
                fifo_sign[i] <= 1'b0;
                fifo_tag[i]  <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_x[wr_ptr]    <= alu_x;
                fifo_zero[wr_ptr] <= alu_zero;
                fifo_sign[wr_ptr] <= alu_sign;
                fifo_tag[wr_ptr]  <= iss_tag;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a behavioural ALU,
// an expected-response queue and a final CHECKS/ERRORS summary.
module tb_alu_issue;

    localparam int DEPTH = 4;
    localparam int TAGW  = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_x;
    logic        alu_zero;
    logic        alu_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_x;
    logic        rsp_zero;
    logic        rsp_sign;
    logic [7:0]  rsp_tag;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [41:0] exp_q[$];
    logic [7:0]  tag_m;

    alu_issue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_x(alu_x), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
        .rsp_tag(rsp_tag), .count(count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
        logic [31:0] x;
        case (op[2:0])
            3'd0: x = a + b;
            3'd1: x = a - b;
            3'd2: x = a & b;
            3'd3: x = a | b;
            3'd4: x = a ^ b;
            3'd5: x = a << b[4:0];
            3'd6: x = a >> b[4:0];
            default: x = ~(a | b);
        endcase
        if (op[3]) x = ~x;
        return {x, (x == 32'd0), x[31]};
    endfunction

    always_comb begin
        {alu_x, alu_zero, alu_sign} = alu_ref(alu_a, alu_b, alu_op);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO must never exceed DEPTH, and rsp_valid tracks occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (count <= 3'(DEPTH) && rsp_valid == (count != 3'd0))
            else begin
                errors++;
                $display("FAIL fifo_bound count=%0d rsp_valid=%0b", count, rsp_valid);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        tag_m     = '0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one request; queue its expected response if it will be accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        if (req_ready) begin
            exp_q.push_back({alu_ref(a, b, op), tag_m});
            tag_m++;
        end
    endtask

    task automatic drain_check(input int n);
        int w;
        rsp_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!rsp_valid && w < 10) begin
                tick();
                w++;
            end
            if (!rsp_valid) begin
                check("drain_timeout", 64'(rsp_valid), 64'd1);
                break;
            end
            check("rsp_head", 64'({rsp_x, rsp_zero, rsp_sign, rsp_tag}), 64'(exp_q.pop_front()));
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        int popped;
        int cyc;
        int not_ready;
        int sent;
        logic idle_bad;

        rst_n = 1'b1;
        #2;
        do_reset();

        // Reset values
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_alu", 64'({alu_a, alu_op}), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_x, rsp_zero, rsp_sign, rsp_tag}), 64'd0);
        check("rst_count", 64'(count), 64'd0);

        // Single request: 1234 + 5678 = 6912
        send(32'd1234, 32'd5678, 6'd0);
        tick();
        req_valid = 1'b0;
        check("single_alu_a", 64'(alu_a), 64'd1234);
        check("single_alu_b", 64'(alu_b), 64'd5678);
        check("single_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_x", 64'(rsp_x), 64'd6912);
        check("single_flags", 64'({rsp_zero, rsp_sign}), 64'd0);
        check("single_tag", 64'(rsp_tag), 64'd0);
        check("single_count", 64'(count), 64'd1);
        drain_check(1);

        // Fill with consumer stalled
        do_reset();
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) accepted++;
            send(32'd100 + 32'(i), 32'(7 * i), 6'(i));
            tick();
        end
        check("fill_accepted", 64'(accepted), 64'd4);
        check("fill_ready_low", 64'(req_ready), 64'd0);
        check("fill_count", 64'(count), 64'd4);
        rsp_ready = 1'b1;
        check("fill_no_comb_path", 64'(req_ready), 64'd0);
        check("fill_head_tag0", 64'({rsp_x, rsp_zero, rsp_sign, rsp_tag}), 64'(exp_q.pop_front()));
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("fill_ready_after_pop", 64'(req_ready), 64'd1);
        check("fill_count_after_pop", 64'(count), 64'd3);
        drain_check(3);

        // Simultaneous push and pop at count = 2
        do_reset();
        send(32'h11, 32'h22, 6'd1);
        tick();
        send(32'h33, 32'h44, 6'd2);
        tick();
        req_valid = 1'b0;
        tick();
        check("pp_count_pre", 64'(count), 64'd2);
        send(32'h55, 32'h66, 6'd4);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("pp_head_tag_pre", 64'(rsp_tag), 64'd0);
        check("pp_count_mid", 64'(count), 64'd2);
        tick();
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        check("pp_count_post", 64'(count), 64'd2);
        check("pp_head_tag_post", 64'(rsp_tag), 64'd1);
        drain_check(2);

        // Streaming 300 requests with consumer always ready
        do_reset();
        rsp_ready = 1'b1;
        popped = 0;
        cyc = 0;
        not_ready = 0;
        sent = 0;
        while (popped < 300 && cyc < 400) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    check("stream_head", 64'({rsp_x, rsp_zero, rsp_sign, rsp_tag}),
                          64'(exp_q.pop_front()));
                end
                if (popped == 256) check("stream_tag_wrap", 64'(rsp_tag), 64'd0);
                popped++;
            end
            if (sent < 300) begin
                if (!req_ready) not_ready++;
                else sent++;
                send(32'h82345671, 32'h83455555, 6'(sent - 1));
            end else begin
                req_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("stream_popped", 64'(popped), 64'd300);
        check("stream_cycles", 64'(cyc), 64'd302);
        check("stream_never_stalled", 64'(not_ready), 64'd0);

        // Reset mid-flight: three queued, one in issue
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(32'(i + 1), 32'd3, 6'd0);
            tick();
        end
        req_valid = 1'b0;
        check("mid_count_pre", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_count", 64'(count), 64'd0);
        check("mid_req_ready", 64'(req_ready), 64'd1);
        do_reset();
        send(32'd11, 32'd22, 6'd1);
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_new_tag", 64'(rsp_tag), 64'd0);
        check("mid_new_valid", 64'(rsp_valid), 64'd1);

        // Idle hold
        send(32'hDEADBEEF, 32'd4, 6'd5);
        tick();
        req_valid = 1'b0;
        drain_check(2);
        idle_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (alu_a !== 32'hDEADBEEF || alu_b !== 32'd4 || alu_op !== 6'd5 || count !== 3'd0)
                idle_bad = 1'b1;
            tick();
        end
        check("idle_hold", 64'(idle_bad), 64'd0);
        check("idle_alu", 64'({alu_a, alu_op}), 64'({32'hDEADBEEF, 6'd5}));
        check("idle_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
